// File: rtl/tmds_pkg.sv
`default_nettype none
// tmds_pkg: shared DVI 1.0 TMDS constants and the 8-bit population count helper.
package tmds_pkg;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  localparam int CNT_W = 5;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_encoder.sv
`default_nettype none
// tmds_encoder: DVI 1.0 TMDS 8b/10b encoder for one channel, two-stage pipeline
// (transition minimisation, then DC balance with a signed running disparity).
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       pix_clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds
);

  localparam logic signed [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;

  logic [8:0]              q_m_next;
  logic [8:0]              q_m;
  logic                    de_s1;
  logic [1:0]              ctrl_s1;
  logic signed [CNT_W-1:0] cnt;

  logic [3:0]              n1d;
  logic                    use_xnor;
  logic [3:0]              n1;
  logic [3:0]              n0;
  logic signed [CNT_W-1:0] diff;
  logic signed [CNT_W-1:0] bias;
  logic signed [CNT_W-1:0] cnt_next;
  logic [9:0]              sym_next;

  always_comb begin
    n1d         = popcount8(data);
    use_xnor    = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
    q_m_next    = '0;
    q_m_next[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i]) : (q_m_next[i-1] ^ data[i]);
    end
    q_m_next[8] = ~use_xnor;
  end

  // diff is N1-N0 of the stage-1 word; bias is the 2*q_m[8] correction term.
  always_comb begin
    n1       = popcount8(q_m[7:0]);
    n0       = 4'd8 - n1;
    diff     = $signed({1'b0, n1}) - $signed({1'b0, n0});
    bias     = q_m[8] ? CNT_TWO : CNT_ZERO;
    sym_next = {1'b0, q_m[8], q_m[7:0]};
    cnt_next = cnt;
    if ((cnt == CNT_ZERO) || (n1 == 4'd4)) begin
      sym_next = q_m[8] ? {2'b01, q_m[7:0]} : {2'b10, ~q_m[7:0]};
      cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[CNT_W-1] && (n1 > 4'd4)) || (cnt[CNT_W-1] && (n1 < 4'd4))) begin
      sym_next = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + bias - diff;
    end else begin
      sym_next = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt + diff - (CNT_TWO - bias);
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      q_m     <= '0;
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
      tmds    <= CTRL_00;
      cnt     <= CNT_ZERO;
    end else begin
      q_m     <= q_m_next;
      de_s1   <= de;
      ctrl_s1 <= ctrl;
      if (de_s1) begin
        tmds <= sym_next;
        cnt  <= cnt_next;
      end else begin
        cnt <= CNT_ZERO;
        case (ctrl_s1)
          2'b00:   tmds <= CTRL_00;
          2'b01:   tmds <= CTRL_01;
          2'b10:   tmds <= CTRL_10;
          default: tmds <= CTRL_11;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder.sv
`default_nettype none
// tb_tmds_encoder: scoreboard bench for tmds_encoder against a DVI 1.0 reference model.
module tb_tmds_encoder;

  logic       pix_clk = 1'b0;
  logic       rst;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [9:0] tmds;

  always #5 pix_clk = ~pix_clk;

  tmds_encoder dut (
    .pix_clk (pix_clk),
    .rst     (rst),
    .de      (de),
    .data    (data),
    .ctrl    (ctrl),
    .tmds    (tmds)
  );

  typedef struct {
    logic [9:0]  sym;
    logic        de;
    logic [7:0]  d;
    int          cnt;
    logic [10:0] fixed;
  } exp_t;

  exp_t sb[$];
  int   m_cnt;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic de_i, input logic [7:0] d,
                                       input logic [1:0] c, inout int cnt_m);
    int         ones;
    int         k1;
    int         k0;
    logic [8:0] q;
    logic [9:0] s;
    ones = 0;
    k1   = 0;
    q    = '0;
    s    = '0;
    if (!de_i) begin
      cnt_m = 0;
      case (c)
        2'b00:   s = 10'h354;
        2'b01:   s = 10'h0AB;
        2'b10:   s = 10'h154;
        default: s = 10'h2AB;
      endcase
      return s;
    end
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    q[0] = d[0];
    if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    for (int i = 0; i < 8; i++) k1 += int'(q[i]);
    k0 = 8 - k1;
    if (cnt_m == 0 || k1 == k0) begin
      if (q[8]) begin
        s = {2'b01, q[7:0]};
        cnt_m += k1 - k0;
      end else begin
        s = {2'b10, ~q[7:0]};
        cnt_m += k0 - k1;
      end
    end else if ((cnt_m > 0 && k1 > k0) || (cnt_m < 0 && k0 > k1)) begin
      s = {1'b1, q[8], ~q[7:0]};
      cnt_m += (q[8] ? 2 : 0) + k0 - k1;
    end else begin
      s = {1'b0, q[8], q[7:0]};
      cnt_m += k1 - k0 - (q[8] ? 0 : 2);
    end
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w;
    logic [7:0] o;
    w    = s[9] ? ~s[7:0] : s[7:0];
    o    = '0;
    o[0] = w[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return o;
  endfunction

  function automatic int dut_cnt();
    return int'(dut.cnt);
  endfunction

  task automatic step(input logic de_i, input logic [7:0] d, input logic [1:0] c,
                      input logic [10:0] fixed);
    exp_t e;
    @(negedge pix_clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("sym", 32'(tmds), 32'(e.sym));
      check("cnt", dut_cnt(), e.cnt);
      check("cnt_bound", 32'(dut_cnt() >= -8 && dut_cnt() <= 8), 32'd1);
      if (e.fixed[10]) check("directed", 32'(tmds), 32'(e.fixed[9:0]));
      if (e.de) check("decode", 32'(decode(tmds)), 32'(e.d));
    end
    rst  = 1'b0;
    de   = de_i;
    data = d;
    ctrl = c;
    e.sym   = model(de_i, d, c, m_cnt);
    e.de    = de_i;
    e.d     = d;
    e.cnt   = m_cnt;
    e.fixed = fixed;
    sb.push_back(e);
  endtask

  // Inputs are left in active video during reset to show they are ignored.
  task automatic do_reset(input int n);
    exp_t f;
    @(negedge pix_clk);
    rst  = 1'b1;
    de   = 1'b1;
    data = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge pix_clk);
      check("rst_sym", 32'(tmds), 32'h354);
      check("rst_cnt", dut_cnt(), 0);
    end
    sb.delete();
    m_cnt   = 0;
    f.sym   = 10'h354;
    f.de    = 1'b0;
    f.d     = 8'h00;
    f.cnt   = 0;
    f.fixed = {1'b1, 10'h354};
    sb.push_back(f);
    sb.push_back(f);
  endtask

  logic [9:0] ctrl_syms [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  int         active;

  initial begin
    rst  = 1'b1;
    de   = 1'b0;
    data = 8'h00;
    ctrl = 2'b00;
    m_cnt = 0;
    do_reset(3);

    repeat (4) step(1'b0, 8'h00, 2'b00, {1'b1, 10'h354});
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 2'(c), {1'b1, ctrl_syms[c]});
    step(1'b0, 8'h00, 2'b00, {1'b1, 10'h354});

    for (int i = 0; i < 9; i++) step(1'b1, 8'h00, 2'b00, {1'b1, (i % 2 == 0) ? 10'h100 : 10'h3FF});
    step(1'b0, 8'h00, 2'b00, {1'b1, 10'h354});
    step(1'b1, 8'hFF, 2'b00, {1'b1, 10'h200});
    step(1'b1, 8'hFF, 2'b00, {1'b1, 10'h0FF});

    active = 0;
    while (active < 10000) begin
      if ($urandom_range(0, 31) != 0) begin
        step(1'b1, 8'($urandom), 2'b00, 11'd0);
        active++;
      end else begin
        step(1'b0, 8'h00, 2'($urandom_range(0, 3)), 11'd0);
      end
    end

    step(1'b0, 8'h00, 2'b00, 11'd0);
    step(1'b1, 8'h00, 2'b00, {1'b1, 10'h100});
    step(1'b1, 8'h0F, 2'b00, 11'd0);
    step(1'b1, 8'h00, 2'b00, 11'd0);
    do_reset(2);
    step(1'b1, 8'h00, 2'b00, {1'b1, 10'h100});
    step(1'b1, 8'h00, 2'b00, {1'b1, 10'h3FF});
    step(1'b0, 8'h00, 2'b00, {1'b1, 10'h354});
    step(1'b0, 8'h00, 2'b00, {1'b1, 10'h354});
    step(1'b0, 8'h00, 2'b00, {1'b1, 10'h354});
    step(1'b0, 8'h00, 2'b00, {1'b1, 10'h354});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
